// File: rtl/norm2_pkg.sv
// Shared constants and saturation-bound helpers for the norm2 multiplier pipeline.
package norm2_pkg;

    localparam int MAX_NUM_STAGE  = 6;
    localparam int MAX_PROD_WIDTH = 128;

    typedef logic [MAX_PROD_WIDTH-1:0] bound_t;

    typedef enum logic [1:0] {
        NARROW_PASS,
        NARROW_TRUNC,
        NARROW_USAT,
        NARROW_SSAT
    } narrow_mode_e;

    // Largest unsigned value representable in 'width' bits.
    function automatic bound_t umax_bound(input int width);
        bound_t r;
        r = '0;
        for (int i = 0; i < MAX_PROD_WIDTH; i++) begin
            r[i] = (i < width);
        end
        return r;
    endfunction

    function automatic bound_t smax_bound(input int width);
        return umax_bound(width - 1);
    endfunction

    // Two's-complement -2^(width-1), sign-extended to the full bound width.
    function automatic bound_t smin_bound(input int width);
        return ~smax_bound(width);
    endfunction

    function automatic narrow_mode_e narrow_mode(input int p_width, input int dout_width,
                                                 input bit sat_en, input bit res_signed);
        if (dout_width >= p_width) return NARROW_PASS;
        else if (!sat_en)          return NARROW_TRUNC;
        else if (!res_signed)      return NARROW_USAT;
        else                       return NARROW_SSAT;
    endfunction

endpackage

// File: rtl/norm2_mul_sat.sv
// Combinational narrowing of the full-width product to the output width, with
// optional saturation and a flag reporting that the result was clipped.
module norm2_mul_sat
    import norm2_pkg::*;
#(
    parameter int P_WIDTH    = 31,
    parameter int DOUT_WIDTH = 31,
    parameter bit RES_SIGNED = 1'b0,
    parameter bit SAT_EN     = 1'b0
) (
    input  logic [P_WIDTH-1:0]    i_prod,
    output logic [DOUT_WIDTH-1:0] o_dout,
    output logic                  o_sat
);

    localparam narrow_mode_e L_MODE = narrow_mode(P_WIDTH, DOUT_WIDTH, SAT_EN, RES_SIGNED);

    generate
        if (L_MODE == NARROW_PASS) begin : g_pass
            assign o_dout = i_prod;
            assign o_sat  = 1'b0;
        end else if (L_MODE == NARROW_TRUNC) begin : g_trunc
            logic w_unused_msbs;
            assign w_unused_msbs = ^i_prod[P_WIDTH-1:DOUT_WIDTH];
            assign o_dout        = i_prod[DOUT_WIDTH-1:0];
            assign o_sat         = 1'b0;
        end else if (L_MODE == NARROW_USAT) begin : g_usat
            localparam bound_t             L_UMAX_FULL = umax_bound(DOUT_WIDTH);
            localparam logic [P_WIDTH-1:0] L_UMAX      = L_UMAX_FULL[P_WIDTH-1:0];
            logic w_over;
            assign w_over = (i_prod > L_UMAX);
            assign o_dout = w_over ? '1 : i_prod[DOUT_WIDTH-1:0];
            assign o_sat  = w_over;
        end else begin : g_ssat
            localparam bound_t             L_SMAX_FULL = smax_bound(DOUT_WIDTH);
            localparam bound_t             L_SMIN_FULL = smin_bound(DOUT_WIDTH);
            localparam logic [P_WIDTH-1:0] L_SMAX      = L_SMAX_FULL[P_WIDTH-1:0];
            localparam logic [P_WIDTH-1:0] L_SMIN      = L_SMIN_FULL[P_WIDTH-1:0];
            logic w_hi;
            logic w_lo;
            assign w_hi   = ($signed(i_prod) > $signed(L_SMAX));
            assign w_lo   = ($signed(i_prod) < $signed(L_SMIN));
            assign o_dout = w_hi ? L_SMAX[DOUT_WIDTH-1:0] :
                            w_lo ? L_SMIN[DOUT_WIDTH-1:0] : i_prod[DOUT_WIDTH-1:0];
            assign o_sat  = w_hi || w_lo;
        end
    endgenerate

endmodule

// File: rtl/norm2_mul_pipe.sv
// Stall-all pipelined multiplier with valid/ready handshake: operands are registered
// in stage 0, multiplied in stage 1, and narrowed/saturated into the final stage.
module norm2_mul_pipe
    import norm2_pkg::*;
#(
    parameter int ID          = 1,
    parameter int NUM_STAGE   = 3,
    parameter int DIN0_WIDTH  = 25,
    parameter int DIN1_WIDTH  = 6,
    parameter int DOUT_WIDTH  = 31,
    parameter int DIN0_SIGNED = 0,
    parameter int DIN1_SIGNED = 0,
    parameter int SAT_EN      = 0
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIN0_WIDTH-1:0] din0,
    input  logic [DIN1_WIDTH-1:0] din1,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DOUT_WIDTH-1:0] dout,
    output logic                  sat_flag,
    output logic                  busy
);

    localparam int P_WIDTH     = DIN0_WIDTH + DIN1_WIDTH;
    localparam bit RES_SIGNED  = (DIN0_SIGNED != 0) || (DIN1_SIGNED != 0);
    localparam int L_UNUSED_ID = ID;

    // Extend both operands to the full product width so a P-bit multiply yields
    // the exact product for any signed/unsigned mix.
    function automatic logic [P_WIDTH-1:0] mul_ext(input logic [DIN0_WIDTH-1:0] a,
                                                   input logic [DIN1_WIDTH-1:0] b);
        logic [P_WIDTH-1:0] ea;
        logic [P_WIDTH-1:0] eb;
        ea = {{DIN1_WIDTH{(DIN0_SIGNED != 0) && a[DIN0_WIDTH-1]}}, a};
        eb = {{DIN0_WIDTH{(DIN1_SIGNED != 0) && b[DIN1_WIDTH-1]}}, b};
        return ea * eb;
    endfunction

    generate
        if (NUM_STAGE == 0) begin : g_comb
            logic w_unused_clk_rst;
            assign w_unused_clk_rst = ap_clk ^ ap_rst;

            norm2_mul_sat #(
                .P_WIDTH   (P_WIDTH),
                .DOUT_WIDTH(DOUT_WIDTH),
                .RES_SIGNED(RES_SIGNED),
                .SAT_EN    (SAT_EN != 0)
            ) u_sat (
                .i_prod(mul_ext(din0, din1)),
                .o_dout(dout),
                .o_sat (sat_flag)
            );

            assign out_valid = in_valid;
            assign in_ready  = out_ready;
            assign busy      = 1'b0;
        end else begin : g_pipe
            logic [NUM_STAGE-1:0]  r_valid;
            logic [P_WIDTH-1:0]    w_final_in;
            logic [DOUT_WIDTH-1:0] w_dout;
            logic                  w_sat;
            logic                  w_stall;
            logic [DOUT_WIDTH-1:0] r_dout;
            logic                  r_sat;

            // NOTE: in_ready is combinational from out_ready so a consumer releasing
            // backpressure lets a new input enter in the very same cycle.
            assign w_stall = r_valid[NUM_STAGE-1] && !out_ready;

            always_ff @(posedge ap_clk or posedge ap_rst) begin
                if (ap_rst) begin
                    r_valid <= '0;
                end else if (!w_stall) begin
                    r_valid[0] <= in_valid;
                    for (int s = 1; s < NUM_STAGE; s++) begin
                        r_valid[s] <= r_valid[s-1];
                    end
                end
            end

            if (NUM_STAGE == 1) begin : g_single
                assign w_final_in = mul_ext(din0, din1);
            end else begin : g_multi
                logic [P_WIDTH-1:0] r_data [0:NUM_STAGE-2];

                for (genvar s = 0; s < NUM_STAGE - 1; s++) begin : g_stage
                    logic [P_WIDTH-1:0] w_next;

                    if (s == 0) begin : g_operands
                        assign w_next = {din0, din1};
                    end else if (s == 1) begin : g_multiply
                        assign w_next = mul_ext(r_data[0][P_WIDTH-1:DIN1_WIDTH],
                                                r_data[0][DIN1_WIDTH-1:0]);
                    end else begin : g_delay
                        assign w_next = r_data[s-1];
                    end

                    // NOTE: data registers are reset too; it is cheap at these
                    // depths and keeps dout deterministic straight out of reset.
                    always_ff @(posedge ap_clk or posedge ap_rst) begin
                        if (ap_rst) begin
                            r_data[s] <= '0;
                        end else if (!w_stall) begin
                            r_data[s] <= w_next;
                        end
                    end
                end

                if (NUM_STAGE == 2) begin : g_mul_last
                    assign w_final_in = mul_ext(r_data[0][P_WIDTH-1:DIN1_WIDTH],
                                                r_data[0][DIN1_WIDTH-1:0]);
                end else begin : g_prod_last
                    assign w_final_in = r_data[NUM_STAGE-2];
                end
            end

            norm2_mul_sat #(
                .P_WIDTH   (P_WIDTH),
                .DOUT_WIDTH(DOUT_WIDTH),
                .RES_SIGNED(RES_SIGNED),
                .SAT_EN    (SAT_EN != 0)
            ) u_sat (
                .i_prod(w_final_in),
                .o_dout(w_dout),
                .o_sat (w_sat)
            );

            always_ff @(posedge ap_clk or posedge ap_rst) begin
                if (ap_rst) begin
                    r_dout <= '0;
                    r_sat  <= 1'b0;
                end else if (!w_stall) begin
                    r_dout <= w_dout;
                    r_sat  <= w_sat;
                end
            end

            assign out_valid = r_valid[NUM_STAGE-1];
            assign in_ready  = !w_stall;
            assign busy      = |r_valid;
            assign dout      = r_dout;
            assign sat_flag  = r_sat;
        end
    endgenerate

endmodule

// File: tb/tb_norm2_mul_pipe.sv
// Bench for norm2_mul_pipe: five pipelined configurations share one input stream and
// are compared every cycle against a queue-based reference; a combinational variant rides along.
module tb_norm2_mul_pipe;

    localparam int N  = 3;
    localparam int P  = 31;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b1;
    logic [24:0] din0      = '0;
    logic [5:0]  din1      = '0;

    logic [4:0]  ov, ir, bz, sf;
    logic [30:0] dout_a, dout_s;
    logic [15:0] dout_u, dout_t, dout_ss;
    logic        ov_c, ir_c, bz_c, sf_c;
    logic [30:0] dout_c;

    always #5 clk = ~clk;

    norm2_mul_pipe u_dut (
        .ap_clk(clk), .ap_rst(rst), .in_valid(in_valid), .in_ready(ir[0]),
        .din0(din0), .din1(din1), .out_valid(ov[0]), .out_ready(out_ready),
        .dout(dout_a), .sat_flag(sf[0]), .busy(bz[0]));

    norm2_mul_pipe #(.DIN0_SIGNED(1)) u_sgn (
        .ap_clk(clk), .ap_rst(rst), .in_valid(in_valid), .in_ready(ir[1]),
        .din0(din0), .din1(din1), .out_valid(ov[1]), .out_ready(out_ready),
        .dout(dout_s), .sat_flag(sf[1]), .busy(bz[1]));

    norm2_mul_pipe #(.DOUT_WIDTH(16), .SAT_EN(1)) u_usat (
        .ap_clk(clk), .ap_rst(rst), .in_valid(in_valid), .in_ready(ir[2]),
        .din0(din0), .din1(din1), .out_valid(ov[2]), .out_ready(out_ready),
        .dout(dout_u), .sat_flag(sf[2]), .busy(bz[2]));

    norm2_mul_pipe #(.DOUT_WIDTH(16), .SAT_EN(0)) u_trunc (
        .ap_clk(clk), .ap_rst(rst), .in_valid(in_valid), .in_ready(ir[3]),
        .din0(din0), .din1(din1), .out_valid(ov[3]), .out_ready(out_ready),
        .dout(dout_t), .sat_flag(sf[3]), .busy(bz[3]));

    norm2_mul_pipe #(.DIN0_SIGNED(1), .DIN1_SIGNED(1), .DOUT_WIDTH(16), .SAT_EN(1)) u_ssat (
        .ap_clk(clk), .ap_rst(rst), .in_valid(in_valid), .in_ready(ir[4]),
        .din0(din0), .din1(din1), .out_valid(ov[4]), .out_ready(out_ready),
        .dout(dout_ss), .sat_flag(sf[4]), .busy(bz[4]));

    norm2_mul_pipe #(.NUM_STAGE(0)) u_comb (
        .ap_clk(clk), .ap_rst(rst), .in_valid(in_valid), .in_ready(ir_c),
        .din0(din0), .din1(din1), .out_valid(ov_c), .out_ready(out_ready),
        .dout(dout_c), .sat_flag(sf_c), .busy(bz_c));

    typedef struct {
        bit          v;
        logic [24:0] a;
        logic [5:0]  b;
    } item_t;

    item_t       pipe[$];
    item_t       cur;
    bit          cur_stall;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_recv   = 0;
    logic [24:0] sa [8];
    logic [5:0]  sb [8];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic longint ref_prod(input logic [24:0] a, input logic [5:0] b,
                                        input bit s0, input bit s1);
        longint x;
        longint y;
        x = longint'(a);
        y = longint'(b);
        if (s0 && a[24]) x = x - (longint'(1) << 25);
        if (s1 && b[5])  y = y - (longint'(1) << 6);
        return x * y;
    endfunction

    // Expected dout/sat for configuration cfg (matches instance order above).
    function automatic logic [63:0] ref_out(input int cfg, input logic [24:0] a,
                                            input logic [5:0] b, output bit flag);
        bit          s0, s1, sat;
        int          dw;
        longint      p, r, hi, lo;
        logic [63:0] mask;
        case (cfg)
            0:       begin s0 = 0; s1 = 0; dw = 31; sat = 0; end
            1:       begin s0 = 1; s1 = 0; dw = 31; sat = 0; end
            2:       begin s0 = 0; s1 = 0; dw = 16; sat = 1; end
            3:       begin s0 = 0; s1 = 0; dw = 16; sat = 0; end
            default: begin s0 = 1; s1 = 1; dw = 16; sat = 1; end
        endcase
        p    = ref_prod(a, b, s0, s1);
        mask = (64'd1 << dw) - 64'd1;
        flag = 1'b0;
        r    = p;
        if (sat && dw < P) begin
            if (!(s0 || s1)) begin
                hi = (longint'(1) << dw) - 1;
                if (p > hi) begin r = hi; flag = 1'b1; end
            end else begin
                hi = (longint'(1) << (dw - 1)) - 1;
                lo = -(longint'(1) << (dw - 1));
                if (p > hi)      begin r = hi; flag = 1'b1; end
                else if (p < lo) begin r = lo; flag = 1'b1; end
            end
        end
        return r & mask;
    endfunction

    function automatic logic [63:0] obs_dout(input int cfg);
        case (cfg)
            0:       return 64'(dout_a);
            1:       return 64'(dout_s);
            2:       return 64'(dout_u);
            3:       return 64'(dout_t);
            default: return 64'(dout_ss);
        endcase
    endfunction

    task automatic reset_model();
        item_t bubble;
        bubble.v = 1'b0;
        bubble.a = '0;
        bubble.b = '0;
        pipe.delete();
        for (int i = 0; i < N; i++) pipe.push_back(bubble);
    endtask

    task automatic check_reset_state(input string tag);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("%s_out_valid%0d", tag, k), 64'(ov[k]), 64'd0);
            check($sformatf("%s_busy%0d", tag, k), 64'(bz[k]), 64'd0);
            check($sformatf("%s_in_ready%0d", tag, k), 64'(ir[k]), 64'd1);
            check($sformatf("%s_sat%0d", tag, k), 64'(sf[k]), 64'd0);
            check($sformatf("%s_dout%0d", tag, k), obs_dout(k), 64'd0);
        end
    endtask

    // Drive one cycle's inputs, then compare every output at the falling edge.
    task automatic sample(input bit v, input logic [24:0] a, input logic [5:0] b, input bit rdy);
        item_t       head;
        logic [63:0] e;
        bit          f;
        bit          exp_busy;
        in_valid  = v;
        din0      = a;
        din1      = b;
        out_ready = rdy;
        cur.v     = v;
        cur.a     = a;
        cur.b     = b;
        @(negedge clk);
        head      = pipe[N-1];
        exp_busy  = 1'b0;
        foreach (pipe[i]) exp_busy = exp_busy | pipe[i].v;
        cur_stall = head.v && !rdy;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("out_valid%0d", k), 64'(ov[k]), 64'(head.v));
            check($sformatf("in_ready%0d", k), 64'(ir[k]), 64'(!cur_stall));
            check($sformatf("busy%0d", k), 64'(bz[k]), 64'(exp_busy));
            if (head.v) begin
                e = ref_out(k, head.a, head.b, f);
                check($sformatf("dout%0d", k), obs_dout(k), e);
                check($sformatf("sat%0d", k), 64'(sf[k]), 64'(f));
            end
        end
        if (ov[0] && rdy) n_recv++;
        e = ref_out(0, a, b, f);
        check("comb_dout", 64'(dout_c), e);
        check("comb_sat", 64'(sf_c), 64'(f));
        check("comb_out_valid", 64'(ov_c), 64'(v));
        check("comb_in_ready", 64'(ir_c), 64'(rdy));
        check("comb_busy", 64'(bz_c), 64'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (!cur_stall) begin
            void'(pipe.pop_back());
            pipe.push_front(cur);
        end
    endtask

    task automatic cyc(input bit v, input logic [24:0] a, input logic [5:0] b, input bit rdy);
        sample(v, a, b, rdy);
        tick();
    endtask

    initial begin
        rst = 1'b1;
        reset_model();
        #12;
        check_reset_state("por");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed products: full-scale, signed -1*2, 16-bit saturate vs truncate.
        cyc(1'b1, 25'h1FFFFFF, 6'd63, 1'b1);
        cyc(1'b1, 25'h1FFFFFF, 6'd2, 1'b1);
        cyc(1'b1, 25'd2000, 6'd63, 1'b1);
        sample(1'b0, '0, '0, 1'b1);
        check("max_product_valid", 64'(ov[0]), 64'd1);
        check("max_product", 64'(dout_a), 64'd2113929153);
        check("max_product_sat", 64'(sf[0]), 64'd0);
        tick();
        sample(1'b0, '0, '0, 1'b1);
        check("signed_minus_two", 64'(dout_s), 64'h7FFFFFFE);
        tick();
        sample(1'b0, '0, '0, 1'b1);
        check("usat16_dout", 64'(dout_u), 64'hFFFF);
        check("usat16_flag", 64'(sf[2]), 64'd1);
        check("trunc16_dout", 64'(dout_t), 64'hEC30);
        check("trunc16_flag", 64'(sf[3]), 64'd0);
        tick();

        // Signed clamp at both ends of the 16-bit range.
        cyc(1'b1, 25'h0FFFFFF, 6'h20, 1'b1);
        cyc(1'b1, 25'h0FFFFFF, 6'd31, 1'b1);
        cyc(1'b0, '0, '0, 1'b1);
        sample(1'b0, '0, '0, 1'b1);
        check("ssat_low", 64'(dout_ss), 64'h8000);
        check("ssat_low_flag", 64'(sf[4]), 64'd1);
        tick();
        sample(1'b0, '0, '0, 1'b1);
        check("ssat_high", 64'(dout_ss), 64'h7FFF);
        check("ssat_high_flag", 64'(sf[4]), 64'd1);
        tick();

        // Eight back-to-back inputs with out_ready low for five cycles mid-stream.
        for (int i = 0; i < 8; i++) begin
            sa[i] = 25'($urandom);
            sb[i] = 6'($urandom);
        end
        n_recv = 0;
        begin
            int k;
            k = 0;
            for (int c = 0; c < 24; c++) begin
                bit rdy;
                bit v;
                rdy = !(c >= 5 && c < 10);
                v   = (k < 8);
                sample(v, v ? sa[k] : 25'd0, v ? sb[k] : 6'd0, rdy);
                if (c >= 5 && c < 10) check("stall_in_ready", 64'(ir[0]), 64'd0);
                if (v && !cur_stall) k++;
                tick();
            end
        end
        check("stream_count", 64'(n_recv), 64'd8);

        // Random traffic with corner operands and random backpressure.
        for (int c = 0; c < 80; c++) begin
            int          r;
            logic [24:0] a;
            logic [5:0]  b;
            r = $urandom_range(0, 3);
            a = (r == 0) ? 25'd0 : (r == 1) ? 25'h1FFFFFF : 25'($urandom);
            b = (r == 2) ? 6'h3F : 6'($urandom);
            cyc(bit'($urandom_range(0, 1)), a, b, $urandom_range(0, 3) != 0);
        end

        // Reset with three items in flight: nothing may emerge afterwards.
        cyc(1'b1, 25'd111, 6'd3, 1'b1);
        cyc(1'b1, 25'd222, 6'd5, 1'b1);
        cyc(1'b1, 25'd333, 6'd7, 1'b1);
        rst = 1'b1;
        #1;
        check_reset_state("mid_reset");
        reset_model();
        @(posedge clk);
        #1;
        rst    = 1'b0;
        n_recv = 0;
        cyc(1'b0, '0, '0, 1'b1);
        cyc(1'b0, '0, '0, 1'b1);
        cyc(1'b1, 25'd12345, 6'd17, 1'b1);
        cyc(1'b0, '0, '0, 1'b1);
        cyc(1'b0, '0, '0, 1'b1);
        sample(1'b0, '0, '0, 1'b1);
        check("post_reset_valid", 64'(ov[0]), 64'd1);
        check("post_reset_dout", 64'(dout_a), 64'd209865);
        tick();
        check("post_reset_count", 64'(n_recv), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
